// File: rtl/qtable_maxq_if.sv
// Handshake/bus bundle for qtable_maxq: table writes, clear requests and max-Q queries.
interface qtable_maxq_if #(
  parameter int STATE_BITS  = 6,
  parameter int ACTION_BITS = 2,
  parameter int DATA_WIDTH  = 32
);
  localparam int ADDR_WIDTH = STATE_BITS + ACTION_BITS;

  logic                   i_clear;
  logic                   o_busy;
  logic                   i_wr_en;
  logic [ADDR_WIDTH-1:0]  i_wr_addr;
  logic [DATA_WIDTH-1:0]  i_wr_data;
  logic                   i_rd_valid;
  logic                   o_rd_ready;
  logic [STATE_BITS-1:0]  i_rd_state;
  logic [ACTION_BITS-1:0] i_rd_action;
  logic                   o_q_valid;
  logic [DATA_WIDTH-1:0]  o_q_max;
  logic [ACTION_BITS-1:0] o_q_argmax;
  logic [DATA_WIDTH-1:0]  o_q_sel;

  modport slave (
    input  i_clear, i_wr_en, i_wr_addr, i_wr_data, i_rd_valid, i_rd_state, i_rd_action,
    output o_busy, o_rd_ready, o_q_valid, o_q_max, o_q_argmax, o_q_sel
  );

  modport master (
    output i_clear, i_wr_en, i_wr_addr, i_wr_data, i_rd_valid, i_rd_state, i_rd_action,
    input  o_busy, o_rd_ready, o_q_valid, o_q_max, o_q_argmax, o_q_sel
  );
endinterface

// File: rtl/qtable_maxq.sv
// Q-table in one block RAM with a sequential max/argmax scan over all actions of a state.
module qtable_maxq #(
  parameter int STATE_BITS  = 6,
  parameter int ACTION_BITS = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  qtable_maxq_if.slave bus
);
  localparam int ADDR_WIDTH = STATE_BITS + ACTION_BITS;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {CLEAR, IDLE, SCAN, FINAL} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [STATE_BITS-1:0]   q_state;
  logic [ACTION_BITS-1:0]  q_action;
  logic [ACTION_BITS-1:0]  scan_idx;
  logic                    cmp_en;
  logic                    cmp_first;
  logic                    cmp_last;
  logic [ACTION_BITS-1:0]  cmp_act;
  logic                    done;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic signed [DATA_WIDTH-1:0] best;
  logic signed [DATA_WIDTH-1:0] sel_val;
  logic [ACTION_BITS-1:0]  best_act;
  logic                    q_valid;
  logic [DATA_WIDTH-1:0]   q_max;
  logic [ACTION_BITS-1:0]  q_argmax;
  logic [DATA_WIDTH-1:0]   q_sel;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // The sweep owns the write port while clearing; user writes are dropped then.
  assign mem_we    = (state == CLEAR) || bus.i_wr_en;
  assign mem_waddr = (state == CLEAR) ? sweep_addr : bus.i_wr_addr;
  assign mem_wdata = (state == CLEAR) ? '0 : bus.i_wr_data;
  assign rd_addr   = {q_state, scan_idx};

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_we && (mem_waddr == rd_addr)) rd_data <= mem_wdata;
    else                                  rd_data <= mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      scan_idx   <= '0;
      cmp_en     <= 1'b0;
      cmp_first  <= 1'b0;
      cmp_last   <= 1'b0;
      cmp_act    <= '0;
      done       <= 1'b0;
      q_valid    <= 1'b0;
      q_max      <= '0;
      q_argmax   <= '0;
      q_sel      <= '0;
    end else begin
      cmp_en    <= 1'b0;
      cmp_first <= 1'b0;
      cmp_last  <= 1'b0;
      done      <= 1'b0;
      q_valid   <= done;

      if (done) begin
        q_max    <= best;
        q_argmax <= best_act;
        q_sel    <= sel_val;
      end

      // Strictly-greater update keeps the lowest action index on ties.
      if (cmp_en) begin
        if (cmp_first || (rd_data > best)) begin
          best     <= rd_data;
          best_act <= cmp_act;
        end
        if (cmp_act == q_action) sel_val <= rd_data;
        done <= cmp_last;
      end

      case (state)
        CLEAR: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == '1) state <= IDLE;
        end
        IDLE: begin
          if (bus.i_clear) begin
            sweep_addr <= '0;
            state      <= CLEAR;
          end else if (bus.i_rd_valid) begin
            q_state  <= bus.i_rd_state;
            q_action <= bus.i_rd_action;
            scan_idx <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          cmp_en    <= 1'b1;
          cmp_act   <= scan_idx;
          cmp_first <= (scan_idx == '0);
          scan_idx  <= scan_idx + 1'b1;
          if (scan_idx == '1) begin
            cmp_last <= 1'b1;
            state    <= FINAL;
          end
        end
        FINAL: state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.o_busy     = (state == CLEAR);
  assign bus.o_rd_ready = (state == IDLE);
  assign bus.o_q_valid  = q_valid;
  assign bus.o_q_max    = q_max;
  assign bus.o_q_argmax = q_argmax;
  assign bus.o_q_sel    = q_sel;
endmodule

// File: tb/tb_qtable_maxq.sv
// Randomized self-checking bench for qtable_maxq against an array model of the Q-table.
module tb_qtable_maxq;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   modelQ [256];

  qtable_maxq_if #(.STATE_BITS(6), .ACTION_BITS(2), .DATA_WIDTH(32)) bus ();

  qtable_maxq #(.STATE_BITS(6), .ACTION_BITS(2), .DATA_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 256; i++) modelQ[i] = 0;
  endtask

  task automatic writeEntry(input int addr, input int data);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = 8'(addr);
    bus.i_wr_data = data;
    @(negedge clk);
    bus.i_wr_en   = 1'b0;
    modelQ[addr]  = data;
  endtask

  // Called at the negedge where the sweep is first visible; a write to address 1
  // is attempted at sample injectAt and must be ignored by the table.
  task automatic waitSweep(input string tag, input int injectAt, output int validSeen);
    int cnt;
    cnt = 0;
    validSeen = 0;
    while (bus.o_busy === 1'b1 && cnt < 1000) begin
      if (bus.o_q_valid === 1'b1) validSeen++;
      if (cnt == injectAt) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = 8'd1;
        bus.i_wr_data = 77;
      end else begin
        bus.i_wr_en = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    bus.i_wr_en = 1'b0;
    checkOutput({tag, " busy cycles"}, cnt, 256);
    checkOutput({tag, " ready after sweep"}, bus.o_rd_ready, 1);
  endtask

  // One query; optional write to {st,injAct} in the cycle the last action is read.
  task automatic applyStimulus(input string tag, input int st, input int act,
                               input int injAct, input int injData);
    int vals [4];
    int expMax, expArg, guard;
    guard = 0;
    while (bus.o_rd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " ready"}, bus.o_rd_ready, 1);
    for (int a = 0; a < 4; a++) vals[a] = modelQ[st*4 + a];
    bus.i_rd_valid  = 1'b1;
    bus.i_rd_state  = 6'(st);
    bus.i_rd_action = 2'(act);
    @(negedge clk);
    bus.i_rd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) checkOutput({tag, " ready low in scan"}, bus.o_rd_ready, 0);
      if (k == 3 && injAct >= 0) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = 8'(st*4 + injAct);
        bus.i_wr_data = injData;
        modelQ[st*4 + injAct] = injData;
        if (injAct == 3) vals[3] = injData;
      end
      if (k == 4) bus.i_wr_en = 1'b0;
      if (k == 5) checkOutput({tag, " valid early"}, bus.o_q_valid, 0);
      if (k == 6) begin
        expMax = vals[0];
        expArg = 0;
        for (int a = 1; a < 4; a++)
          if (vals[a] > expMax) begin
            expMax = vals[a];
            expArg = a;
          end
        checkOutput({tag, " valid"}, bus.o_q_valid, 1);
        checkOutput({tag, " max"}, $signed(bus.o_q_max), expMax);
        checkOutput({tag, " argmax"}, bus.o_q_argmax, expArg);
        checkOutput({tag, " sel"}, $signed(bus.o_q_sel), vals[act]);
      end
      if (k == 7) begin
        checkOutput({tag, " valid one cycle"}, bus.o_q_valid, 0);
        checkOutput({tag, " max held"}, $signed(bus.o_q_max), expMax);
      end
    end
  endtask

  initial begin
    int validSeen, guard, nAcc, d, st, act, injAct;
    int accIdx [4];
    compared   = 0;
    mismatched = 0;
    rst_n           = 1'b0;
    bus.i_clear     = 1'b0;
    bus.i_wr_en     = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_rd_valid  = 1'b0;
    bus.i_rd_state  = '0;
    bus.i_rd_action = '0;
    clearModel();

    repeat (3) @(negedge clk);
    checkOutput("reset busy", bus.o_busy, 1);
    checkOutput("reset ready", bus.o_rd_ready, 0);
    checkOutput("reset valid", bus.o_q_valid, 0);
    checkOutput("reset max", $signed(bus.o_q_max), 0);
    rst_n = 1'b1;
    waitSweep("init sweep", -10, validSeen);
    applyStimulus("empty state5", 5, 0, -1, 0);

    writeEntry(3*4 + 0, 10);
    writeEntry(3*4 + 1, -5);
    writeEntry(3*4 + 2, 40);
    writeEntry(3*4 + 3, 40);
    applyStimulus("state3 tie", 3, 1, -1, 0);

    writeEntry(7*4 + 0, -1);
    writeEntry(7*4 + 1, -2);
    writeEntry(7*4 + 2, -3);
    writeEntry(7*4 + 3, -4);
    applyStimulus("state7 negative", 7, 3, -1, 0);

    applyStimulus("state3 forward", 3, 0, 3, 100);

    guard = 0;
    while (bus.o_rd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.i_rd_valid  = 1'b1;
    bus.i_rd_state  = 6'd3;
    bus.i_rd_action = 2'd0;
    @(negedge clk);
    bus.i_rd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midscan reset valid", bus.o_q_valid, 0);
    checkOutput("midscan reset max", $signed(bus.o_q_max), 0);
    checkOutput("midscan reset argmax", bus.o_q_argmax, 0);
    checkOutput("midscan reset sel", $signed(bus.o_q_sel), 0);
    waitSweep("midscan sweep", -10, validSeen);
    checkOutput("aborted query valid", validSeen, 0);
    clearModel();
    applyStimulus("state3 after reset", 3, 2, -1, 0);

    // Back-to-back queries with the request held high.
    nAcc = 0;
    bus.i_rd_valid  = 1'b1;
    bus.i_rd_state  = 6'd9;
    bus.i_rd_action = 2'd1;
    for (int c = 0; c < 40 && nAcc < 4; c++) begin
      if (bus.o_rd_ready === 1'b1) begin
        accIdx[nAcc] = c;
        nAcc++;
      end
      if (nAcc < 4) @(negedge clk);
    end
    bus.i_rd_valid = 1'b0;
    checkOutput("held valid accepts", nAcc, 4);
    for (int i = 1; i < 4; i++) checkOutput("held valid gap", accIdx[i] - accIdx[i-1], 6);
    repeat (10) @(negedge clk);

    // Clear wins over a simultaneous query; a write during the sweep is dropped.
    writeEntry(0*4 + 2, 55);
    bus.i_clear    = 1'b1;
    bus.i_rd_valid = 1'b1;
    bus.i_rd_state = 6'd0;
    @(negedge clk);
    bus.i_clear    = 1'b0;
    bus.i_rd_valid = 1'b0;
    waitSweep("clear sweep", 200, validSeen);
    checkOutput("clear no query", validSeen, 0);
    clearModel();
    applyStimulus("state0 after clear", 0, 1, -1, 0);

    for (int q = 0; q < 24; q++) begin
      st = $urandom_range(0, 63);
      for (int a = 0; a < 4; a++) begin
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 1) == 1) d = int'($urandom_range(0, 6)) - 3;
          else d = int'($urandom);
          writeEntry(st*4 + a, d);
        end
      end
      writeEntry(int'($urandom_range(0, 255)), int'($urandom));
      act    = $urandom_range(0, 3);
      injAct = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      applyStimulus("random query", st, act, injAct, int'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/qtable_maxq.md
QTABLE_MAXQ -- requirements
Module: qtable_maxq

Interface
REQ-001 SHALL have parameter STATE_BITS, default 6, meaning state index width (64 states).
REQ-002 SHALL have parameter ACTION_BITS, default 2, meaning action index width (NUM_ACTIONS = 2**ACTION_BITS).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning signed two's-complement fixed-point Q-value width.
REQ-004 SHALL derive ADDR_WIDTH = STATE_BITS+ACTION_BITS, DEPTH = 2**ADDR_WIDTH, address = {state, action}.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port i_clear, input, 1, request a zero sweep of the table.
REQ-008 SHALL have port o_busy, output, 1, zero sweep in progress.
REQ-009 SHALL have port i_wr_en, input, 1, write strobe.
REQ-010 SHALL have port i_wr_addr, input, ADDR_WIDTH, write address.
REQ-011 SHALL have port i_wr_data, input, DATA_WIDTH, write data.
REQ-012 SHALL have port i_rd_valid, input, 1, max-query request.
REQ-013 SHALL have port o_rd_ready, output, 1, query can be accepted.
REQ-014 SHALL have port i_rd_state, input, STATE_BITS, queried state.
REQ-015 SHALL have port i_rd_action, input, ACTION_BITS, action whose Q-value is also returned.
REQ-016 SHALL have port o_q_valid, output, 1, one-cycle result strobe.
REQ-017 SHALL have port o_q_max, output, DATA_WIDTH, max over actions of Q(state,a).
REQ-018 SHALL have port o_q_argmax, output, ACTION_BITS, action achieving o_q_max.
REQ-019 SHALL have port o_q_sel, output, DATA_WIDTH, Q(state, i_rd_action).

Function
REQ-020 SHALL store DEPTH words in one inferred block RAM, one read port and one write port, 1-cycle read latency.
REQ-021 SHALL use FSM states CLEAR, IDLE, SCAN, FINAL; o_rd_ready = 1 only in IDLE; o_busy = 1 only in CLEAR.
REQ-022 CLEAR: write zero to address 0..DEPTH-1, one per cycle, then go to IDLE; duration exactly DEPTH cycles.
REQ-023 IDLE: i_clear=1 -> CLEAR (i_clear wins over simultaneous i_rd_valid); else i_rd_valid=1 -> capture state/action, go to SCAN.
REQ-024 SCAN: issue reads for actions 0..NUM_ACTIONS-1 on consecutive cycles, then FINAL for one cycle, then IDLE.
REQ-025 Query accepted at edge T -> o_q_valid high for exactly cycle T+NUM_ACTIONS+2, with results valid that cycle; next query acceptable that same edge.
REQ-026 Compare SHALL be signed; update only on strictly greater, so ties resolve to lowest action index.
REQ-027 o_q_max, o_q_argmax, o_q_sel SHALL hold their last values until the next o_q_valid.
REQ-028 i_wr_en outside CLEAR SHALL write i_wr_data at that edge; writes during CLEAR SHALL be ignored.
REQ-029 Write and scan read to the same address in the same cycle SHALL return the new data (write-first forwarding).
REQ-030 i_clear outside IDLE SHALL be ignored; i_rd_valid outside IDLE SHALL not be accepted.

Reset
REQ-031 i_rst_n=0 at an edge SHALL set FSM to CLEAR with sweep address 0, o_q_valid=0, o_q_max=0, o_q_argmax=0, o_q_sel=0, o_rd_ready=0.
REQ-032 Reset mid-SCAN SHALL abort the query with no o_q_valid; table contents after the following sweep are all zero.
REQ-033 Table contents SHALL NOT require reset beyond the sweep; o_busy=1 during the sweep.

Verification
REQ-034 Release reset -> o_busy high 256 cycles, o_rd_ready then 1; query state 5 action 0 -> max 0, argmax 0, sel 0.
REQ-035 Write Q(3,0..3)=10,-5,40,40; query state 3 action 1 accepted at T -> o_q_valid at T+6, max 40, argmax 2, sel -5.
REQ-036 Q(7,0..3)=-1,-2,-3,-4; query state 7 action 3 -> max -1, argmax 0, sel -4.
REQ-037 Query state 3 with write {3,3}=100 in the cycle action 3 is read -> max 100, argmax 3.
REQ-038 i_rst_n low at T+3 of a query -> no o_q_valid, 256-cycle sweep, re-query state 3 -> max 0; i_rd_valid held high -> queries accepted every 6 cycles.
